// File: rtl/sensor_frame_reader.sv
// Linear optical sensor readout: SI pulse generation, pixel counting, settle-delayed ADC capture
// and a one-entry valid/ready output stage. Optional frame accumulator under SENSOR_FRAME_SUM_EN.
module sensor_frame_reader #(
    parameter int NUM_PIXELS = 128,
    parameter int DATA_W     = 8,
    parameter int SETTLE     = 3,
    parameter int IDX_W      = 7
) (
    input  logic              clk_3M,
    input  logic              reset,
    input  logic              sensor_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              start,
    output logic              sensor_si,
    output logic [DATA_W-1:0] pixel_data,
    output logic [IDX_W-1:0]  pixel_idx,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef SENSOR_FRAME_SUM_EN
    ,
    output logic [DATA_W+IDX_W-1:0] frame_sum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SI_HI,
        S_SI_LO,
        S_READ,
        S_FLUSH
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PIXELS - 1);
    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);

    state_t              state_q, state_d;
    logic                sclk_q;
    logic                si_q, si_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [3:0]          tmr_q, tmr_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   pixel_data_q, pixel_data_d;
    logic [IDX_W-1:0]    pixel_idx_q, pixel_idx_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                overrun_q, overrun_d;

    logic rise;
    logic fall;
    logic capture;
    logic handshake;
    logic drop;

    assign rise = sensor_clk & ~sclk_q;
    assign fall = ~sensor_clk & sclk_q;

    always_comb begin
        state_d = state_q;
        si_d    = si_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (fall) begin
                    si_d    = 1'b1;
                    state_d = S_SI_HI;
                end
            end
            S_SI_HI: begin
                if (rise) begin
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                    tmr_d   = SETTLE_CNT;
                    state_d = S_SI_LO;
                end
            end
            S_SI_LO, S_READ: begin
                // A pending capture masks any rise; pixel 0 may still be settling in SI_LO.
                if (pend_q) begin
                    if (tmr_q == 4'd1) begin
                        capture = 1'b1;
                        pend_d  = 1'b0;
                        if (cnt_q == LAST_IDX) begin
                            state_d = S_FLUSH;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        tmr_d = tmr_q - 4'd1;
                    end
                end else if (rise && (state_q == S_READ)) begin
                    pend_d = 1'b1;
                    tmr_d  = SETTLE_CNT;
                end
                if ((state_q == S_SI_LO) && fall) begin
                    si_d    = 1'b0;
                    state_d = S_READ;
                end
            end
            S_FLUSH: begin
                if (rise) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-entry holding register: a capture refills it only if empty or draining this cycle.
    always_comb begin
        pixel_data_d  = pixel_data_q;
        pixel_idx_d   = pixel_idx_q;
        pixel_valid_d = pixel_valid_q;
        overrun_d     = overrun_q;
        handshake     = pixel_valid_q & pixel_ready;
        drop          = capture & pixel_valid_q & ~pixel_ready;
        if (capture && !drop) begin
            pixel_data_d  = adc_data;
            pixel_idx_d   = cnt_q;
            pixel_valid_d = 1'b1;
        end else if (handshake) begin
            pixel_valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_3M or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            sclk_q        <= 1'b0;
            si_q          <= 1'b0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            tmr_q         <= '0;
            done_q        <= 1'b0;
            pixel_data_q  <= '0;
            pixel_idx_q   <= '0;
            pixel_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_q        <= sensor_clk;
            si_q          <= si_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            tmr_q         <= tmr_d;
            done_q        <= done_d;
            pixel_data_q  <= pixel_data_d;
            pixel_idx_q   <= pixel_idx_d;
            pixel_valid_q <= pixel_valid_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef SENSOR_FRAME_SUM_EN
    localparam int SUM_W = DATA_W + IDX_W;

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] frame_sum_q, frame_sum_d;

    // Dropped samples are still summed; the total is published with frame_done.
    always_comb begin
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        if ((state_q == S_IDLE) && start) begin
            sum_d = '0;
        end else if (capture) begin
            sum_d = sum_q + SUM_W'(adc_data);
        end
        if (done_d) begin
            frame_sum_d = sum_q;
        end
    end

    always_ff @(posedge clk_3M or negedge reset) begin
        if (!reset) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_q       <= sum_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`endif

    assign sensor_si   = si_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_idx   = pixel_idx_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sensor_frame_reader.sv
// Bench for sensor_frame_reader: per-frame event schedule predicted from the sensor_clk pattern,
// checked every cycle against a one-entry output buffer model.
module tb_sensor_frame_reader;

    localparam int NP   = 4;
    localparam int DW   = 8;
    localparam int ST   = 3;
    localparam int IW   = 3;
    localparam int SW   = DW + IW;
    localparam int PH   = 1;
    localparam int HIST = 4096;

    logic          clk_3M      = 1'b0;
    logic          reset       = 1'b0;
    logic          sensor_clk  = 1'b0;
    logic [DW-1:0] adc_data    = '0;
    logic          start       = 1'b0;
    logic          pixel_ready = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          sensor_si;
    logic [DW-1:0] pixel_data;
    logic [IW-1:0] pixel_idx;
    logic          pixel_valid;
    logic          frame_done;
    logic          busy;
    logic          overrun;
`ifdef SENSOR_FRAME_SUM_EN
    logic [SW-1:0] frame_sum;
`endif

    sensor_frame_reader #(
        .NUM_PIXELS(NP),
        .DATA_W    (DW),
        .SETTLE    (ST),
        .IDX_W     (IW)
    ) dut (
        .clk_3M     (clk_3M),
        .reset      (reset),
        .sensor_clk (sensor_clk),
        .adc_data   (adc_data),
        .start      (start),
        .sensor_si  (sensor_si),
        .pixel_data (pixel_data),
        .pixel_idx  (pixel_idx),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
`ifdef SENSOR_FRAME_SUM_EN
        ,
        .frame_sum  (frame_sum)
`endif
    );

    always #5 clk_3M = ~clk_3M;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [DW-1:0] adc_at [HIST];
    int rdy_mode = 0;   // 0 always ready, 1 never, 2 random, 3 only on capture edges
    int dat_mode = 2;   // 0 ramp 0x10+i, 1 all 0xFF, 2 random

    // Reference model: frame schedule plus output buffer contents
    bit            in_rst;
    bit            f_act;
    int            f_s, f_f1, f_f2, f_rn, nxt;
    int            cap_e [NP];
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_idx;
    bit            m_valid, m_ovr, m_done, m_busy, m_si;
    logic [SW-1:0] m_sum, m_fsum;

    // Level of sensor_clk presented at edge e: a divide-by-4 square wave
    function automatic bit lvl(int e);
        return ((e + PH) / 2) % 2 == 1;
    endfunction

    function automatic int next_edge(int e, bit want_rise);
        int x;
        x = e + 1;
        while (!(want_rise ? (lvl(x) && !lvl(x - 1)) : (!lvl(x) && lvl(x - 1)))) x++;
        return x;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        f_act = 0; nxt = 0;
        m_data = '0; m_idx = '0;
        m_valid = 0; m_ovr = 0; m_done = 0; m_busy = 0; m_si = 0;
        m_sum = '0; m_fsum = '0;
    endtask

    // Frame accepted at edge c: SI rises on the first fall, pixel 0 comes from the next rise,
    // later pixels from the first rise after each capture, and one extra rise closes the frame.
    task automatic schedule(int c);
        int r;
        f_act = 1; f_s = c; nxt = 0; m_sum = '0;
        f_f1 = next_edge(c, 0);
        r    = next_edge(f_f1, 1);
        f_f2 = next_edge(r, 0);
        for (int i = 0; i < NP; i++) begin
            if (i > 0) r = next_edge(r + ST, 1);
            cap_e[i] = r + ST;
            if (dat_mode == 0) adc_at[(r + ST) % HIST] = DW'(8'h10 + i);
            else if (dat_mode == 1) adc_at[(r + ST) % HIST] = '1;
        end
        f_rn = next_edge(r + ST, 1);
    endtask

    task automatic model_step();
        bit cap_now, drop, hs, idle_before;
        logic [DW-1:0] smp;
        if (in_rst) return;
        idle_before = !f_act;
        m_done  = f_act && (cyc == f_rn);
        cap_now = f_act && (nxt < NP) && (cyc == cap_e[nxt]);
        hs      = m_valid && pixel_ready;
        drop    = cap_now && m_valid && !pixel_ready;
        if (cap_now) begin
            smp   = adc_at[cyc % HIST];
            m_sum = m_sum + SW'(smp);
            if (!drop) begin
                m_data  = smp;
                m_idx   = IW'(nxt);
                m_valid = 1;
                $display("[TB] cycle %0d pixel idx=%0d data=%02h loaded", cyc, nxt, smp);
            end else begin
                $display("[TB] cycle %0d pixel idx=%0d data=%02h dropped", cyc, nxt, smp);
            end
            nxt++;
        end else if (hs) begin
            m_valid = 0;
        end
        if (overrun_clr) m_ovr = 0;
        if (drop) m_ovr = 1;
        if (m_done) begin
            m_fsum = m_sum;
            f_act  = 0;
            $display("[TB] cycle %0d frame_done", cyc);
        end
        if (idle_before && start) schedule(cyc);
        m_busy = f_act && (cyc < f_rn);
        m_si   = f_act && (cyc >= f_f1) && (cyc < f_f2);
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("sensor_si", 32'(sensor_si), 32'(m_si));
        chk("pixel_valid", 32'(pixel_valid), 32'(m_valid));
        chk("pixel_data", 32'(pixel_data), 32'(m_data));
        chk("pixel_idx", 32'(pixel_idx), 32'(m_idx));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SENSOR_FRAME_SUM_EN
        chk("frame_sum", 32'(frame_sum), 32'(m_fsum));
`endif
    endtask

    task automatic drive_next();
        int e;
        e = cyc + 1;
        sensor_clk = lvl(e);
        adc_data   = adc_at[e % HIST];
        case (rdy_mode)
            0:       pixel_ready = 1'b1;
            1:       pixel_ready = 1'b0;
            2:       pixel_ready = 1'($urandom_range(0, 1));
            default: pixel_ready = f_act && (nxt < NP) && (e == cap_e[nxt]);
        endcase
    endtask

    task automatic tick();
        @(posedge clk_3M);
        #1;
        cyc++;
        model_step();
        compare();
        drive_next();
    endtask

    task automatic rst_release();
        #2;
        reset  = 1'b1;
        in_rst = 0;
    endtask

    task automatic run_frame(int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < HIST; i++) adc_at[i] = DW'($urandom);
        model_clear();
        in_rst = 1;
        drive_next();
        repeat (4) tick();
        rst_release();
        repeat (3) tick();

        // Frame with ramp data and a permanently ready sink
        dat_mode = 0; rdy_mode = 0;
        run_frame(40);
        chk("A_overrun", 32'(overrun), 32'd0);
`ifdef SENSOR_FRAME_SUM_EN
        chk("A_frame_sum", 32'(frame_sum), 32'h46);
`endif

        // Sink never ready: pixel 0 held, the rest dropped
        rdy_mode = 1;
        run_frame(40);
        chk("B_held_valid", 32'(pixel_valid), 32'd1);
        chk("B_held_idx", 32'(pixel_idx), 32'd0);
        chk("B_held_data", 32'(pixel_data), 32'h10);
        chk("B_overrun", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("B_overrun_clr", 32'(overrun), 32'd0);
        repeat (2) tick();
        rdy_mode = 0;
        repeat (3) tick();

        // Ready only in the cycles a new sample is captured
        dat_mode = 2; rdy_mode = 3;
        run_frame(40);
        chk("C_overrun", 32'(overrun), 32'd0);

        // Reset in the middle of READ after pixel 2
        rdy_mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (nxt < 3 && n < 60) begin
            tick();
            n++;
        end
        chk("D_reach_pixel2", 32'(nxt), 32'd3);
        #2;
        reset  = 1'b0;
        in_rst = 1;
        model_clear();
        #1;
        compare();
        repeat (3) tick();
        rst_release();
        repeat (3) tick();
        run_frame(40);

        // start held high: back-to-back frames
        dat_mode = 1; rdy_mode = 0;
        start = 1'b1;
        repeat (70) tick();
        start = 1'b0;
        repeat (40) tick();
`ifdef SENSOR_FRAME_SUM_EN
        chk("F_frame_sum", 32'(frame_sum), 32'h3FC);
`endif

        // start pulsed while busy is ignored
        dat_mode = 2; rdy_mode = 2;
        run_frame(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        chk("G_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sensor_frame_reader.md
Name: sensor_frame_reader

Overview:
- Readout controller for the linear optical sensor, running in the clk_3M domain.
- Uses the divided sensor_clk to:
  - issue the SI (start-integration) pulse to the sensor,
  - count pixel clock edges,
  - sample the ADC after a settle delay,
  - stream pixels downstream with a valid/ready handshake.
- Sits between the sensor clock divider/ADC and the force-processing logic.

Parameters:
- NUM_PIXELS, 128, pixels per frame; minimum 2.
- DATA_W, 8, ADC sample width.
- SETTLE, 3, clk_3M cycles from sensor_clk rising edge to ADC capture; range 1..15.
- IDX_W, 7, pixel index width; must satisfy 2^IDX_W >= NUM_PIXELS.

Ports:
- clk_3M  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sensor_clk  input  1  divided sensor clock; registered, synchronous to clk_3M.
- adc_data  input  DATA_W  ADC output for the current pixel.
- start  input  1  request one frame; sampled only in IDLE.
- sensor_si  output  1  SI line to the sensor.
- pixel_data  output  DATA_W  captured sample.
- pixel_idx  output  IDX_W  index of pixel_data (0..NUM_PIXELS-1).
- pixel_valid  output  1  pixel_data/pixel_idx valid.
- pixel_ready  input  1  downstream accepts when pixel_valid & pixel_ready.
- frame_done  output  1  one-cycle pulse at end of frame.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  sticky: a sample was dropped.
- overrun_clr  input  1  clears overrun.

Behaviour:

Reset:
- reset low asynchronously forces state IDLE.
- All outputs go to 0: sensor_si, pixel_data, pixel_idx, pixel_valid, frame_done, busy, overrun.
- Also clears the counters and the sensor_clk edge register.
- Reset asserted mid-frame aborts the frame with no frame_done.

Edge detect:
- sclk_d <= sensor_clk.
- rise = sensor_clk & ~sclk_d.
- fall = ~sensor_clk & sclk_d.

FSM:
- IDLE:
  - start=1 -> ARM.
  - busy=0.
- ARM:
  - On fall: sensor_si<=1 -> SI_HI.
- SI_HI:
  - On rise: pixel counter cnt<=0, start settle timer -> SI_LO.
- SI_LO:
  - On fall: sensor_si<=0 -> READ.
  - Settle/capture still runs in this state.
- READ:
  - Each rise after the first restarts the settle timer.
  - When the timer expires (SETTLE cycles after the rise), capture adc_data with index cnt, then cnt++.
  - After the capture with cnt==NUM_PIXELS-1 -> FLUSH.
  - Rises that occur while a capture is still pending are ignored.
- FLUSH:
  - Wait for one more rise (the NUM_PIXELS+1 clock that tri-states the sensor output); no capture.
  - Pulse frame_done for 1 cycle -> IDLE.

Output stage (one-entry holding register):
- On capture:
  - If pixel_valid=0, or pixel_valid & pixel_ready in that same cycle: load pixel_data/pixel_idx and set pixel_valid=1.
  - Otherwise: drop the sample, set overrun=1, keep the held data unchanged.
- pixel_valid clears on handshake when no new capture occurs in that cycle.
- pixel_data/pixel_idx stay stable while pixel_valid=1 and pixel_ready=0.
- frame_done does not wait for the output stage to drain.

Boundaries and timing:
- overrun_clr and a new overrun in the same cycle: set wins.
- start while busy: ignored. start held high in IDLE: immediately re-arms (back-to-back frames).
- cnt never wraps within a frame.
- Latency: pixel_valid rises SETTLE+1 clk_3M cycles after the rise that produced the sample.

Optional Feature:
- Macro: SENSOR_FRAME_SUM_EN.
- Defined:
  - Adds output frame_sum [DATA_W+IDX_W-1:0].
  - Accumulates every captured sample, including dropped ones.
  - Accumulator cleared on entering ARM.
  - frame_sum is updated with the final total in the same cycle frame_done pulses, and holds until the next frame_done.
  - Reset value 0.
- Undefined: port and accumulator are absent; all other behaviour identical.

Test Plan:
- Single frame, NUM_PIXELS=4, SETTLE=3, sensor_clk = clk_3M/4, adc_data = 8'h10+pixel number, pixel_ready=1, start pulse:
  - sensor_si high across exactly one sensor_clk rise.
  - 4 pixels with idx 0..3 and data 10,11,12,13.
  - frame_done one cycle after the 5th rise; overrun=0.
- Backpressure, same setup with pixel_ready=0 throughout:
  - pixel 0 held (idx 0, data 10); pixels 1..3 dropped; overrun=1.
  - overrun_clr pulse -> overrun=0.
- Handshake in capture cycle: pixel_ready=1 exactly in the cycle the next sample is captured -> new sample loaded, no overrun.
- Reset mid-READ after pixel 2:
  - All outputs 0 immediately (asynchronous), no frame_done.
  - Next start yields a clean frame starting at idx 0.
- start held high:
  - Two consecutive frames, each with its own SI pulse and frame_done.
  - start pulsed while busy is ignored.
- With SENSOR_FRAME_SUM_EN: the first scenario gives frame_sum = 0x46 when frame_done pulses; a second frame with all samples 0xFF gives 0x3FC.
